aes128_ecb_decryptor: RTL and testbench



---
 rtl/aes_pkg.sv | 101 ++++++++++
 rtl/aes_inv_round.sv | 49 ++++
 rtl/aes128_ecb_decryptor.sv | 154 +++++++++++++++
 tb/tb_aes128_ecb_decryptor.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: FSM encoding, word typedefs, and the GF(2^8) and S-box helpers.
// The S-boxes are computed from the field inverse and affine map rather than stored as tables.
package aes_pkg;

    localparam int         NR        = 10;
    localparam logic [3:0] LAST_KIDX = 4'd10;

    typedef logic [7:0]   byte_t;
    typedef logic [31:0]  word_t;
    typedef logic [127:0] block_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_KEYEXP = 3'd1,
        ST_READY  = 3'd2,
        ST_DEC    = 3'd3,
        ST_OUT    = 3'd4
    } state_e;

    function automatic byte_t xtime(input byte_t a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic byte_t gf_mul(input byte_t a, input byte_t b);
        byte_t p;
        byte_t x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8); 0 maps to 0.
    function automatic byte_t gf_inv(input byte_t a);
        byte_t p;
        byte_t r;
        p = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic byte_t rotl8(input byte_t a, input logic [2:0] k);
        logic [15:0] t;
        t = {a, a} << k;
        return t[15:8];
    endfunction

    function automatic byte_t sbox(input byte_t a);
        byte_t v;
        v = gf_inv(a);
        return v ^ rotl8(v, 3'd1) ^ rotl8(v, 3'd2) ^ rotl8(v, 3'd3) ^ rotl8(v, 3'd4) ^ 8'h63;
    endfunction

    function automatic byte_t inv_sbox(input byte_t a);
        return gf_inv(rotl8(a, 3'd1) ^ rotl8(a, 3'd3) ^ rotl8(a, 3'd6) ^ 8'h05);
    endfunction

    function automatic byte_t mul9(input byte_t a);
        return xtime(xtime(xtime(a))) ^ a;
    endfunction

    function automatic byte_t mul11(input byte_t a);
        return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
    endfunction

    function automatic byte_t mul13(input byte_t a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
    endfunction

    function automatic byte_t mul14(input byte_t a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
    endfunction

    function automatic byte_t rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic word_t sub_word(input word_t w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns unless this is the final round.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] round_key_i,
    input  logic         last_i,
    output logic [127:0] next_state_o
);

    block_t shifted;
    block_t subbed;
    block_t keyed;
    block_t mixed;
    byte_t  a0, a1, a2, a3;

    always_comb begin
        shifted = '0;
        subbed  = '0;
        mixed   = '0;
        a0      = '0;
        a1      = '0;
        a2      = '0;
        a3      = '0;
        // Byte r+4c is row r, column c; row r rotates right by r columns.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted[8*(r+4*c) +: 8] = state_i[8*(r+4*((c-r)&3)) +: 8];
            end
        end
        for (int i = 0; i < 16; i++) begin
            subbed[8*i +: 8] = inv_sbox(shifted[8*i +: 8]);
        end
        keyed = subbed ^ round_key_i;
        for (int c = 0; c < 4; c++) begin
            a0 = keyed[32*c +: 8];
            a1 = keyed[32*c+8 +: 8];
            a2 = keyed[32*c+16 +: 8];
            a3 = keyed[32*c+24 +: 8];
            mixed[32*c +: 8]    = mul14(a0) ^ mul11(a1) ^ mul13(a2) ^ mul9(a3);
            mixed[32*c+8 +: 8]  = mul9(a0)  ^ mul14(a1) ^ mul11(a2) ^ mul13(a3);
            mixed[32*c+16 +: 8] = mul13(a0) ^ mul9(a1)  ^ mul14(a2) ^ mul11(a3);
            mixed[32*c+24 +: 8] = mul11(a0) ^ mul13(a1) ^ mul9(a2)  ^ mul14(a3);
        end
        next_state_o = last_i ? keyed : mixed;
    end

endmodule

// File: rtl/aes128_ecb_decryptor.sv
// Iterative AES-128 ECB decryptor: expands the key once into eleven stored round keys,
// then runs one inverse round per cycle per block.
module aes128_ecb_decryptor
    import aes_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] key_0,
    input  logic [31:0] key_1,
    input  logic [31:0] key_2,
    input  logic [31:0] key_3,
    input  logic        key_load,
    output logic        key_ready,
    input  logic [31:0] cipher_text_0,
    input  logic [31:0] cipher_text_1,
    input  logic [31:0] cipher_text_2,
    input  logic [31:0] cipher_text_3,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] plain_text_0,
    output logic [31:0] plain_text_1,
    output logic [31:0] plain_text_2,
    output logic [31:0] plain_text_3,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  dbg_state_o
);

    // Handshakes: a block transfers on any edge where in_valid && in_ready (or
    // out_valid && out_ready); valid never depends on ready, and outputs hold while stalled.

    state_e     state_q, state_d;
    logic [3:0] round_q, round_d;
    logic [3:0] kidx_q, kidx_d;
    logic       key_ready_q, key_ready_d;
    block_t     blk_q, blk_d;
    block_t     pt_q, pt_d;
    block_t     rk_q [0:NR];

    block_t     key_w;
    block_t     cipher_w;
    block_t     rk_prev;
    block_t     rk_next;
    block_t     round_out;
    word_t      rk_t;
    word_t      w0, w1, w2, w3;
    logic       key_accept;
    logic       blk_accept;

    assign key_w      = {key_3, key_2, key_1, key_0};
    assign cipher_w   = {cipher_text_3, cipher_text_2, cipher_text_1, cipher_text_0};
    assign key_accept = key_load && (state_q == ST_IDLE || state_q == ST_READY);
    assign blk_accept = in_valid && !key_load && (state_q == ST_READY);

    aes_inv_round u_inv_round (
        .state_i      (blk_q),
        .round_key_i  (rk_q[round_q]),
        .last_i       (round_q == 4'd0),
        .next_state_o (round_out)
    );

    // Word chain for rk[kidx] from rk[kidx-1]; byte 0 sits in the LSBs, so RotWord is a right rotate.
    always_comb begin
        rk_prev = rk_q[kidx_q - 4'd1];
        rk_t    = sub_word({rk_prev[103:96], rk_prev[127:104]}) ^ {24'h0, rcon(kidx_q)};
        w0      = rk_prev[31:0]   ^ rk_t;
        w1      = rk_prev[63:32]  ^ w0;
        w2      = rk_prev[95:64]  ^ w1;
        w3      = rk_prev[127:96] ^ w2;
        rk_next = {w3, w2, w1, w0};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (key_load) state_d = ST_KEYEXP;
            ST_KEYEXP: if (kidx_q == LAST_KIDX) state_d = ST_READY;
            ST_READY: begin
                if (key_load)      state_d = ST_KEYEXP;
                else if (in_valid) state_d = ST_DEC;
            end
            ST_DEC:    if (round_q == 4'd0) state_d = ST_OUT;
            ST_OUT:    if (out_ready) state_d = ST_READY;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready     = (state_q == ST_READY) && !key_load;
        out_valid    = (state_q == ST_OUT);
        key_ready    = key_ready_q;
        dbg_state_o  = state_q;
        plain_text_0 = pt_q[31:0];
        plain_text_1 = pt_q[63:32];
        plain_text_2 = pt_q[95:64];
        plain_text_3 = pt_q[127:96];
    end

    always_comb begin
        round_d     = round_q;
        kidx_d      = kidx_q;
        key_ready_d = key_ready_q;
        blk_d       = blk_q;
        pt_d        = pt_q;
        if (key_accept) begin
            kidx_d      = 4'd1;
            key_ready_d = 1'b0;
        end else if (state_q == ST_KEYEXP) begin
            kidx_d = kidx_q + 4'd1;
            if (kidx_q == LAST_KIDX) key_ready_d = 1'b1;
        end
        if (blk_accept) begin
            blk_d   = cipher_w ^ rk_q[NR];
            round_d = 4'd9;
        end else if (state_q == ST_DEC) begin
            blk_d   = round_out;
            round_d = round_q - 4'd1;
            if (round_q == 4'd0) pt_d = round_out;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            round_q     <= 4'd0;
            kidx_q      <= 4'd0;
            key_ready_q <= 1'b0;
            pt_q        <= '0;
        end else begin
            round_q     <= round_d;
            kidx_q      <= kidx_d;
            key_ready_q <= key_ready_d;
            pt_q        <= pt_d;
        end
    end

    // Round keys and the working block are not reset; key_ready and the FSM gate their use.
    always_ff @(posedge clk) begin
        blk_q <= blk_d;
        if (key_accept) begin
            rk_q[0] <= key_w;
        end else if (state_q == ST_KEYEXP) begin
            rk_q[kidx_q] <= rk_next;
        end
    end

endmodule

// File: tb/tb_aes128_ecb_decryptor.sv
// Directed bench for aes128_ecb_decryptor using FIPS-197 C.1 and the all-zero-key vector.
module tb_aes128_ecb_decryptor;
    import aes_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] key_0, key_1, key_2, key_3;
    logic        key_load;
    logic        key_ready;
    logic [31:0] cipher_text_0, cipher_text_1, cipher_text_2, cipher_text_3;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] plain_text_0, plain_text_1, plain_text_2, plain_text_3;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  dbg_state_o;

    localparam logic [127:0] KEY_C1 = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    localparam logic [127:0] CT_C1  = 128'h5ac5b470_80b7cdd8_30047b6a_d8e0c469;
    localparam logic [127:0] PT_C1  = 128'hffeeddcc_bbaa9988_77665544_33221100;
    localparam logic [127:0] CT_Z   = 128'h2e2b34ca_59fa4c88_3b2c8aef_d44be966;
    localparam logic [127:0] PT_Z   = 128'h0;

    logic [127:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    aes128_ecb_decryptor dut (
        .clk           (clk),
        .reset         (reset),
        .key_0         (key_0),
        .key_1         (key_1),
        .key_2         (key_2),
        .key_3         (key_3),
        .key_load      (key_load),
        .key_ready     (key_ready),
        .cipher_text_0 (cipher_text_0),
        .cipher_text_1 (cipher_text_1),
        .cipher_text_2 (cipher_text_2),
        .cipher_text_3 (cipher_text_3),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .plain_text_0  (plain_text_0),
        .plain_text_1  (plain_text_1),
        .plain_text_2  (plain_text_2),
        .plain_text_3  (plain_text_3),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .dbg_state_o   (dbg_state_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [127:0] plain();
        return {plain_text_3, plain_text_2, plain_text_1, plain_text_0};
    endfunction

    task automatic drive_key(input logic [127:0] k);
        {key_3, key_2, key_1, key_0} = k;
    endtask

    task automatic drive_ct(input logic [127:0] c);
        {cipher_text_3, cipher_text_2, cipher_text_1, cipher_text_0} = c;
    endtask

    task automatic pop_check(input string tag);
        logic [127:0] e;
        check({tag, "_sb_nonempty"}, 128'(exp_q.size() != 0), 128'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check(tag, plain(), e);
        end
    endtask

    // Steps until out_valid is seen or the budget runs out; waited = edges taken.
    task automatic wait_out(input int max_cyc, output int waited);
        waited = 0;
        while (waited < max_cyc && !out_valid) begin
            step();
            waited++;
        end
    endtask

    task automatic wait_key(input int max_cyc, output int waited);
        waited = 0;
        while (waited < max_cyc && !key_ready) begin
            step();
            waited++;
        end
    endtask

    initial begin
        int  waited;
        bit  saw_out;
        bit  hs;
        int  n_acc;
        int  n_out;
        int  acc_cyc [2];

        reset = 1'b1;
        key_load = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        drive_key('0);
        drive_ct('0);
        repeat (3) step();
        check("rst_key_ready", 128'(key_ready), 128'd0);
        check("rst_in_ready", 128'(in_ready), 128'd0);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_plain", plain(), 128'd0);
        reset = 1'b0;
        step();
        check("rst_idle", 128'(dbg_state_o), 128'(ST_IDLE));

        // in_valid before any key: nothing accepted.
        drive_ct(CT_C1);
        in_valid = 1'b1;
        repeat (3) begin
            step();
            check("idle_in_ready", 128'(in_ready), 128'd0);
            check("idle_out_valid", 128'(out_valid), 128'd0);
        end

        // Key load: sampled at edge E0, key_ready visible after edge E10 (cycle t+11).
        drive_key(KEY_C1);
        key_load = 1'b1;
        #1;
        check("idle_in_ready_keyload", 128'(in_ready), 128'd0);
        step();
        key_load = 1'b0;
        drive_key(~KEY_C1);
        saw_out = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            saw_out = saw_out | out_valid;
            if (k <= 5) check("keyexp_in_ready", 128'(in_ready), 128'd0);
            if (k == 5) in_valid = 1'b0;
            if (k == 9) check("key_ready_early", 128'(key_ready), 128'd0);
            if (k == 10) check("key_ready_on_time", 128'(key_ready), 128'd1);
        end
        check("keyexp_no_out", 128'(saw_out), 128'd0);

        // C.1 block: accept at edge A0, out_valid after edge A10 (cycle t+11).
        out_ready = 1'b0;
        drive_ct(CT_C1);
        in_valid = 1'b1;
        #1;
        check("ready_in_ready", 128'(in_ready), 128'd1);
        exp_q.push_back(PT_C1);
        step();
        in_valid = 1'b0;
        drive_ct(~CT_C1);
        wait_out(30, waited);
        check("c1_latency", 128'(waited), 128'd10);
        pop_check("c1_plain");

        // Backpressure: 5 stalled cycles in OUT.
        in_valid = 1'b1;
        repeat (5) begin
            step();
            check("bp_out_valid", 128'(out_valid), 128'd1);
            check("bp_plain", plain(), PT_C1);
            check("bp_in_ready", 128'(in_ready), 128'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_release_out_valid", 128'(out_valid), 128'd0);
        check("bp_release_in_ready", 128'(in_ready), 128'd1);
        check("bp_release_state", 128'(dbg_state_o), 128'(ST_READY));

        // Back-to-back: in_valid and out_ready held high for two C.1 blocks.
        drive_ct(CT_C1);
        in_valid = 1'b1;
        n_acc = 0;
        n_out = 0;
        acc_cyc[0] = 0;
        acc_cyc[1] = 0;
        for (int cyc = 0; cyc < 60 && n_out < 2; cyc++) begin
            hs = in_valid && in_ready;
            if (out_valid) begin
                pop_check("b2b_plain");
                n_out++;
            end
            step();
            if (hs && n_acc < 2) begin
                exp_q.push_back(PT_C1);
                acc_cyc[n_acc] = cyc;
                n_acc++;
                if (n_acc == 2) in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        check("b2b_outputs", 128'(n_out), 128'd2);
        check("b2b_spacing", 128'(acc_cyc[1] - acc_cyc[0]), 128'd12);

        // Key reload in READY, in the same cycle as in_valid.
        repeat ($urandom_range(1, 3)) step();
        drive_key('0);
        drive_ct(CT_Z);
        key_load = 1'b1;
        in_valid = 1'b1;
        #1;
        check("reload_in_ready", 128'(in_ready), 128'd0);
        check("reload_key_ready_before", 128'(key_ready), 128'd1);
        step();
        key_load = 1'b0;
        in_valid = 1'b0;
        check("reload_key_ready_drop", 128'(key_ready), 128'd0);
        check("reload_state", 128'(dbg_state_o), 128'(ST_KEYEXP));
        wait_key(30, waited);
        check("reload_latency", 128'(waited), 128'd10);
        check("reload_no_out", 128'(out_valid), 128'd0);
        in_valid = 1'b1;
        exp_q.push_back(PT_Z);
        step();
        in_valid = 1'b0;
        wait_out(30, waited);
        check("zero_latency", 128'(waited), 128'd10);
        pop_check("zero_plain");
        step();

        // Reset while DEC is at round 5 (four edges after the accept).
        drive_ct(CT_C1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        check("mid_dec_state", 128'(dbg_state_o), 128'(ST_DEC));
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_out_valid", 128'(out_valid), 128'd0);
        check("abort_key_ready", 128'(key_ready), 128'd0);
        check("abort_plain", plain(), 128'd0);
        check("abort_in_ready", 128'(in_ready), 128'd0);
        in_valid = 1'b1;
        repeat (3) begin
            step();
            check("abort_hold_in_ready", 128'(in_ready), 128'd0);
            check("abort_hold_out_valid", 128'(out_valid), 128'd0);
        end
        in_valid = 1'b0;

        // Reload after the abort and decrypt C.1 again.
        drive_key(KEY_C1);
        key_load = 1'b1;
        step();
        key_load = 1'b0;
        wait_key(30, waited);
        check("recover_key_latency", 128'(waited), 128'd10);
        in_valid = 1'b1;
        exp_q.push_back(PT_C1);
        step();
        in_valid = 1'b0;
        wait_out(30, waited);
        check("recover_latency", 128'(waited), 128'd10);
        pop_check("recover_plain");
        step();

        check("sb_empty", 128'(exp_q.size()), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
